spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 111 +++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: three-slave SPI mode-0 master with CS setup/hold/gap timing.
//   clk, rst_n       : system clock, asynchronous active-low reset
//   spi_start[2:0]   : per-slave request, lowest set bit is served
//   spi_dir          : 0 write, 1 read (mosi held low)
//   spi_data_tx      : right-aligned transmit word
//   spi_data_depth   : bit count, 1..24 used as given, anything else means 24
//   spi_ready[2:0]   : all ones while idle
//   spi_sclk/mosi/miso/cs_n : serial bus, cs_n one-hot-low while active
//   spi_data_rx      : right-aligned received word, updated only by reads
//   spi_rx_valid     : one-cycle pulse when a read completes
module spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  spi_start,
   input  logic        spi_dir,
   input  logic [23:0] spi_data_tx,
   input  logic [7:0]  spi_data_depth,
   output logic [2:0]  spi_ready,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic [2:0]  spi_cs_n,
   output logic [23:0] spi_data_rx,
   output logic        spi_rx_valid
);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   localparam logic [7:0] DIV_L   = 8'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_L = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_L  = 8'(CS_HOLD - 1);
   localparam logic [7:0] GAP_L   = 8'(CS_GAP - 1);
   state_t state, state_n;
   logic armed, dir_q, accept, rise, fall, active_n;
   logic [7:0] cnt;
   logic [4:0] depth_q, depth_in, pulses;
   logic [2:0] sel_q, sel_in;
   logic [23:0] tx_sr, rx_sr, tx_al;
   always_comb begin
      sel_in   = spi_start & (~spi_start + 3'd1);
      depth_in = (spi_data_depth != 8'd0 && spi_data_depth <= 8'd24) ? spi_data_depth[4:0] : 5'd24;
      // left-align so the first bit to send always sits at bit 23
      tx_al    = spi_data_tx << (5'd24 - depth_in);
      accept   = state == IDLE && armed && spi_start != 3'b000;
      // the SETUP exit produces the first rising edge; SHIFT produces the rest
      rise     = (state == SETUP && cnt == SETUP_L) ||
                 (state == SHIFT && cnt == DIV_L && !spi_sclk && pulses != depth_q);
      fall     = state == SHIFT && cnt == DIV_L && spi_sclk;
      state_n  = state;
      case (state)
         IDLE:    state_n = accept ? SETUP : IDLE;
         SETUP:   state_n = cnt == SETUP_L ? SHIFT : SETUP;
         SHIFT:   state_n = (cnt == DIV_L && !spi_sclk && pulses == depth_q) ? HOLD : SHIFT;
         HOLD:    state_n = cnt == HOLD_L ? GAP : HOLD;
         GAP:     state_n = cnt == GAP_L ? IDLE : GAP;
         default: state_n = IDLE;
      endcase
      active_n = state_n == SETUP || state_n == SHIFT || state_n == HOLD;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         armed        <= 1'b0;
         cnt          <= 8'd0;
         sel_q        <= 3'b000;
         dir_q        <= 1'b0;
         depth_q      <= 5'd24;
         pulses       <= 5'd0;
         tx_sr        <= 24'd0;
         rx_sr        <= 24'd0;
         spi_cs_n     <= 3'b111;
         spi_sclk     <= 1'b0;
         spi_mosi     <= 1'b0;
         spi_ready    <= 3'b111;
         spi_data_rx  <= 24'd0;
         spi_rx_valid <= 1'b0;
      end else begin
         armed        <= 1'b1;
         state        <= state_n;
         cnt          <= (state_n != state || (state == SHIFT && cnt == DIV_L)) ? 8'd0 : cnt + 8'd1;
         spi_cs_n     <= active_n ? ~(accept ? sel_in : sel_q) : 3'b111;
         spi_ready    <= {3{state_n == IDLE}};
         spi_rx_valid <= state == HOLD && state_n == GAP && dir_q;
         spi_sclk     <= rise ? 1'b1 : fall ? 1'b0 : spi_sclk;
         if (accept) begin
            sel_q    <= sel_in;
            dir_q    <= spi_dir;
            depth_q  <= depth_in;
            tx_sr    <= tx_al;
            rx_sr    <= 24'd0;
            pulses   <= 5'd0;
            spi_mosi <= !spi_dir && tx_al[23];
         end
         if (rise) begin
            pulses <= pulses + 5'd1;
            rx_sr  <= {rx_sr[22:0], spi_miso};
         end
         if (fall) begin
            tx_sr    <= tx_sr << 1;
            spi_mosi <= !dir_q && tx_sr[22];
         end
         if (state == HOLD && state_n == GAP) begin
            spi_mosi <= 1'b0;
            if (dir_q) spi_data_rx <= rx_sr;
         end
      end
   end
endmodule
